// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic multi-channel detector.
//   - FSM state encoding of the shared measurement engine
//   - result class encoding fed to the per-channel debouncers
//   - ch_width(): width of a channel index (never below 1 bit)
package ultrasonic_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_NEAR = 2'd1,
    CLS_FAR  = 2'd2
  } cls_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ultrasonic_debounce.sv
// Per-channel near/far streak counters and the debounced detection flag.
// Ports:
//   clk, rst   system clock, asynchronous active-low reset
//   strobe_i   a result for this channel is being reported this cycle
//   cls_i      class of that result (NONE leaves both streaks untouched)
//   flag_o     debounced object-detected flag
module ultrasonic_debounce
  import ultrasonic_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  input  cls_e cls_i,
  output logic flag_o
);

  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SAT = SW'(DEBOUNCE);

  logic [SW-1:0] near_q, near_d;
  logic [SW-1:0] far_q, far_d;
  logic          flag_q, flag_d;

  always_comb begin
    near_d = near_q;
    far_d  = far_q;
    flag_d = flag_q;
    if (strobe_i) begin
      case (cls_i)
        CLS_NEAR: begin
          far_d = '0;
          if (near_q != SAT) near_d = near_q + SW'(1);
        end
        CLS_FAR: begin
          near_d = '0;
          if (far_q != SAT) far_d = far_q + SW'(1);
        end
        default: ;
      endcase
    end
    // Opposing streak is always cleared, so both cannot be saturated at once.
    if (near_d == SAT)     flag_d = 1'b1;
    else if (far_d == SAT) flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      near_q <= '0;
      far_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      near_q <= near_d;
      far_q  <= far_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/ultrasonic_multi_detector.sv
// N-channel HC-SR04-style proximity detector sharing one measurement engine.
// Channels are served round-robin, one per slot, so neighbours never fire
// together. Each echo width is classified near/far and debounced per channel.
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   enable_i            permits new measurements to start at a slot tick
//   echo_i[N_CH]        raw asynchronous echo lines
//   trigger_o[N_CH]     trigger pulse to the selected sensor
//   object_detected_o   debounced per-channel detection flags
//   meas_valid_o        one-cycle strobe for a completed measurement
//   meas_ch_o           channel of the reported result
//   meas_count_o        echo width in cycles (saturates at ECHO_TIMEOUT)
//   meas_timeout_o      reported result is a timeout
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a slot tick with enable_i high
// TRIG      | trigger_o[ch] high for TRIG_CYCLES
// WAIT_RISE | waiting for the echo to rise, bounded by ECHO_TIMEOUT
// MEASURE   | counting synchronized echo-high cycles
// DONE      | result strobed; channel pointer advances
module ultrasonic_multi_detector
  import ultrasonic_pkg::*;
#(
  parameter int CLOCK_FREQ     = 50_000_000,
  parameter int N_CH           = 2,
  parameter int CNT_W          = 32,
  parameter int TRIG_CYCLES    = CLOCK_FREQ / 100_000,
  parameter int ECHO_TIMEOUT   = (CLOCK_FREQ / 1000) * 28,
  parameter int PERIOD_CYCLES  = (CLOCK_FREQ / 1000) * 60,
  parameter int NEAR_THRESHOLD = 29155,
  parameter int FAR_THRESHOLD  = 32070,
  parameter int DEBOUNCE       = 3,
  localparam int CH_W          = ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [N_CH-1:0]  echo_i,
  output logic [N_CH-1:0]  trigger_o,
  output logic [N_CH-1:0]  object_detected_o,
  output logic             meas_valid_o,
  output logic [CH_W-1:0]  meas_ch_o,
  output logic [CNT_W-1:0] meas_count_o,
  output logic             meas_timeout_o
);

  localparam int SLOT_W  = $clog2(PERIOD_CYCLES);
  localparam int TMR_MAX = (TRIG_CYCLES > ECHO_TIMEOUT) ? TRIG_CYCLES : ECHO_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_CNT    = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0]  NEAR_CNT  = CNT_W'(NEAR_THRESHOLD);
  localparam logic [CNT_W-1:0]  FAR_CNT   = CNT_W'(FAR_THRESHOLD);

  logic [N_CH-1:0]   echo_s1_q, echo_s2_q, echo_s3_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              slot_tick;
  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [N_CH-1:0]   trig_q;
  logic              meas_valid_q, meas_to_q;
  logic [CH_W-1:0]   meas_ch_q;
  logic [CNT_W-1:0]  meas_count_q;

  logic              sel_s2, sel_rise;
  logic              done_now, res_to;
  logic [CNT_W-1:0]  res_cnt;
  cls_e              res_cls;

  // Third stage only serves edge detection on the synchronized value.
  assign sel_s2   = echo_s2_q[ch_q];
  assign sel_rise = echo_s2_q[ch_q] & ~echo_s3_q[ch_q];

  assign slot_tick = (slot_q == SLOT_LAST);
  assign slot_d    = slot_tick ? '0 : slot_q + SLOT_W'(1);

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    done_now = 1'b0;
    res_to   = 1'b0;
    res_cnt  = '0;
    case (state_q)
      ST_IDLE: begin
        if (slot_tick && enable_i) begin
          state_d = ST_TRIG;
          tmr_d   = TMR_W'(TRIG_CYCLES - 1);
        end
      end
      ST_TRIG: begin
        if (tmr_q == '0) begin
          state_d = ST_WAIT_RISE;
          tmr_d   = TMR_W'(ECHO_TIMEOUT - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_WAIT_RISE: begin
        if (sel_rise) begin
          // The cycle that revealed the edge is already one high cycle.
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (tmr_q == '0) begin
          state_d  = ST_DONE;
          done_now = 1'b1;
          res_to   = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        if (cnt_q == TO_CNT) begin
          state_d  = ST_DONE;
          done_now = 1'b1;
          res_to   = 1'b1;
          res_cnt  = cnt_q;
        end else if (!sel_s2) begin
          state_d  = ST_DONE;
          done_now = 1'b1;
          res_cnt  = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    res_cls = CLS_NONE;
    if (res_to || (res_cnt >= FAR_CNT))               res_cls = CLS_FAR;
    else if ((res_cnt != '0) && (res_cnt < NEAR_CNT)) res_cls = CLS_NEAR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_s1_q    <= '0;
      echo_s2_q    <= '0;
      echo_s3_q    <= '0;
      slot_q       <= '0;
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      cnt_q        <= '0;
      ch_q         <= '0;
      trig_q       <= '0;
      meas_valid_q <= 1'b0;
      meas_ch_q    <= '0;
      meas_count_q <= '0;
      meas_to_q    <= 1'b0;
    end else begin
      echo_s1_q    <= echo_i;
      echo_s2_q    <= echo_s1_q;
      echo_s3_q    <= echo_s2_q;
      slot_q       <= slot_d;
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      trig_q       <= (state_d == ST_TRIG) ? (N_CH'(1) << ch_q) : '0;
      meas_valid_q <= done_now;
      if (done_now) begin
        meas_ch_q    <= ch_q;
        meas_count_q <= res_cnt;
        meas_to_q    <= res_to;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_deb
    ultrasonic_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .strobe_i(done_now && (ch_q == CH_W'(i))),
      .cls_i   (res_cls),
      .flag_o  (object_detected_o[i])
    );
  end

  assign trigger_o      = trig_q;
  assign meas_valid_o   = meas_valid_q;
  assign meas_ch_o      = meas_ch_q;
  assign meas_count_o   = meas_count_q;
  assign meas_timeout_o = meas_to_q;

endmodule

// File: tb/tb_ultrasonic_multi_detector.sv
// Directed bench for ultrasonic_multi_detector with small timing parameters.
module tb_ultrasonic_multi_detector;

  localparam int N_CH    = 2;
  localparam int TRIG    = 10;
  localparam int TIMEOUT = 800;
  localparam int PERIOD  = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [1:0]  echo_i;
  logic [1:0]  trigger_o;
  logic [1:0]  object_detected_o;
  logic        meas_valid_o;
  logic [0:0]  meas_ch_o;
  logic [31:0] meas_count_o;
  logic        meas_timeout_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ultrasonic_multi_detector #(
    .CLOCK_FREQ    (50_000_000),
    .N_CH          (N_CH),
    .CNT_W         (32),
    .TRIG_CYCLES   (TRIG),
    .ECHO_TIMEOUT  (TIMEOUT),
    .PERIOD_CYCLES (PERIOD),
    .NEAR_THRESHOLD(100),
    .FAR_THRESHOLD (150),
    .DEBOUNCE      (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_i         (enable_i),
    .echo_i           (echo_i),
    .trigger_o        (trigger_o),
    .object_detected_o(object_detected_o),
    .meas_valid_o     (meas_valid_o),
    .meas_ch_o        (meas_ch_o),
    .meas_count_o     (meas_count_o),
    .meas_timeout_o   (meas_timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic trig_width();
    int n;
    n = 1;
    while (trigger_o != 2'b00 && n < 40) begin
      @(posedge clk); #1;
      if (trigger_o != 2'b00) n++;
    end
    chk("trig_width", n, TRIG);
  endtask

  // Called right after reset release on a falling edge.
  task automatic first_trig();
    repeat (PERIOD - 1) @(posedge clk);
    #1 chk("pre_tick", trigger_o, 2'b00);
    @(posedge clk);
    #1 chk("trig0_rise", trigger_o, 2'b01);
    trig_width();
  endtask

  task automatic wait_trig(input logic [1:0] exp);
    int n;
    n = 0;
    while (trigger_o == 2'b00 && n < 4600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("trig_sel", trigger_o, exp);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!meas_valid_o && n < 1200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_seen", meas_valid_o, 1);
  endtask

  task automatic chk_result(input int ch, input int cnt, input int to, input logic [1:0] flags);
    chk("meas_ch", meas_ch_o, ch);
    chk("meas_count", meas_count_o, cnt);
    chk("meas_timeout", meas_timeout_o, to);
    chk("flags", object_detected_o, flags);
    @(posedge clk);
    #1 chk("strobe_len", meas_valid_o, 0);
    chk("count_hold", meas_count_o, cnt);
  endtask

  // One measurement slot: echo pulse of 'width' cycles on 'mask' lines
  // (width 0 = no echo), starting 20 cycles after the trigger ends.
  task automatic do_slot(input logic [1:0] exp_trig, input logic [1:0] mask,
                         input int width, input bit drop_en, input int exp_ch,
                         input int exp_cnt, input int exp_to, input logic [1:0] exp_flags);
    wait_trig(exp_trig);
    trig_width();
    repeat (20) @(posedge clk);
    @(negedge clk);
    if (width >= TIMEOUT) begin
      echo_i = mask;
      wait_valid();
      chk_result(exp_ch, exp_cnt, exp_to, exp_flags);
      repeat (300) @(negedge clk);
      echo_i = 2'b00;
    end else begin
      if (width > 0) begin
        echo_i = mask;
        repeat (width / 2) @(negedge clk);
        if (drop_en) enable_i = 1'b0;
        repeat (width - width / 2) @(negedge clk);
        echo_i = 2'b00;
        if (mask == exp_trig) begin
          repeat (2) @(posedge clk);
          #1 chk("fall_lat_early", meas_valid_o, 0);
          @(posedge clk);
          #1 chk("fall_lat", meas_valid_o, 1);
        end
      end
      wait_valid();
      chk_result(exp_ch, exp_cnt, exp_to, exp_flags);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    bit seen;
    rst      = 1'b0;
    enable_i = 1'b1;
    echo_i   = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_trig", trigger_o, 0);
    chk("rst_flags", object_detected_o, 0);
    chk("rst_valid", meas_valid_o, 0);
    chk("rst_ch", meas_ch_o, 0);
    chk("rst_count", meas_count_o, 0);
    chk("rst_to", meas_timeout_o, 0);
    rst = 1'b1;

    // Idle echo: ch0 times out exactly TIMEOUT cycles after the trigger ends.
    first_trig();
    repeat (TIMEOUT - 1) @(posedge clk);
    #1 chk("rise_to_early", meas_valid_o, 0);
    @(posedge clk);
    #1 chk("rise_to", meas_valid_o, 1);
    chk_result(0, 0, 1, 2'b00);

    //       trig   mask   width drop ch  cnt  to flags
    do_slot(2'b10, 2'b00,    0, 0,   1,   0, 1, 2'b00);
    do_slot(2'b01, 2'b01,   60, 0,   0,  60, 0, 2'b00);
    do_slot(2'b10, 2'b01,   60, 0,   1,   0, 1, 2'b00);
    do_slot(2'b01, 2'b01,   60, 0,   0,  60, 0, 2'b01);
    do_slot(2'b10, 2'b10,   99, 0,   1,  99, 0, 2'b01);
    do_slot(2'b01, 2'b01,  120, 0,   0, 120, 0, 2'b01);
    do_slot(2'b10, 2'b00,    0, 0,   1,   0, 1, 2'b01);
    do_slot(2'b01, 2'b01,  200, 0,   0, 200, 0, 2'b01);
    do_slot(2'b10, 2'b10,   99, 0,   1,  99, 0, 2'b01);
    do_slot(2'b01, 2'b01,  200, 0,   0, 200, 0, 2'b00);
    do_slot(2'b10, 2'b10,   99, 0,   1,  99, 0, 2'b10);
    do_slot(2'b01, 2'b01,   60, 0,   0,  60, 0, 2'b10);
    do_slot(2'b10, 2'b10,  100, 0,   1, 100, 0, 2'b10);
    do_slot(2'b01, 2'b01,   60, 0,   0,  60, 0, 2'b11);
    do_slot(2'b10, 2'b10,  150, 0,   1, 150, 0, 2'b11);
    do_slot(2'b01, 2'b01, 1000, 0,   0, 800, 1, 2'b11);
    do_slot(2'b10, 2'b10,  150, 0,   1, 150, 0, 2'b01);
    do_slot(2'b01, 2'b01, 1000, 0,   0, 800, 1, 2'b00);
    do_slot(2'b10, 2'b00,    0, 0,   1,   0, 1, 2'b00);
    do_slot(2'b01, 2'b01,   60, 1,   0,  60, 0, 2'b00);

    // Disabled: no trigger across at least two slot ticks.
    seen = 1'b0;
    repeat (4500) begin
      @(posedge clk); #1;
      if (trigger_o != 2'b00) seen = 1'b1;
    end
    chk("no_trig_disabled", seen, 0);
    enable_i = 1'b1;

    do_slot(2'b10, 2'b00,    0, 0,   1,   0, 1, 2'b00);
    do_slot(2'b01, 2'b01,   60, 0,   0,  60, 0, 2'b01);

    // Reset in the middle of the ch1 trigger pulse.
    wait_trig(2'b10);
    #2 rst = 1'b0;
    #1 chk("async_trig", trigger_o, 0);
    chk("async_flags", object_detected_o, 0);
    chk("async_valid", meas_valid_o, 0);
    chk("async_count", meas_count_o, 0);
    chk("async_to", meas_timeout_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    first_trig();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ultrasonic_multi_detector.md
# ultrasonic_multi_detector

Parametrised N-channel ultrasonic proximity detector that drives several HC-SR04-style sensors from one shared measurement engine. Channels are measured round-robin, one per time slot, so adjacent sensors never fire together. Each echo width is compared against near/far thresholds with hysteresis and a consecutive-sample debounce to produce stable per-channel `object_detected_o` flags. Raw measurements are streamed out for the counting logic.

## Interface
- `CLOCK_FREQ`, 50_000_000, clock frequency in Hz (documentation and derived defaults only).
- `N_CH`, 2, number of sensor channels; must be at least 1.
- `CNT_W`, 32, width of the echo counter and the result.
- `TRIG_CYCLES`, 500, trigger pulse width in cycles (10 µs).
- `ECHO_TIMEOUT`, 1_400_000, maximum cycles in the wait-for-rise phase and in the measure phase.
- `PERIOD_CYCLES`, 3_000_000, slot length in cycles (60 ms); must exceed TRIG_CYCLES + 2·ECHO_TIMEOUT + 4.
- `NEAR_THRESHOLD`, 29155, a count strictly below this classifies as near (about 10 cm).
- `FAR_THRESHOLD`, 32070, a count at or above this classifies as far; must be at least NEAR_THRESHOLD.
- `DEBOUNCE`, 3, number of consecutive same-class results needed to change a flag.
- `clk` input 1: single system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `enable_i` input 1: allows new measurements to start.
- `echo_i` input N_CH: raw, asynchronous echo lines.
- `trigger_o` output N_CH: sensor trigger pulses.
- `object_detected_o` output N_CH: debounced detection flags.
- `meas_valid_o` output 1: one-cycle strobe marking a completed measurement.
- `meas_ch_o` output max(1,$clog2(N_CH)): channel of the current result.
- `meas_count_o` output CNT_W: measured echo width in cycles.
- `meas_timeout_o` output 1: the current result is a timeout.

## Operation
- Each `echo_i` bit passes through its own 2-flop synchronizer. All decisions use the synchronized value.
- Slot timer: free-running 0..PERIOD_CYCLES-1. The slot tick fires when the count equals PERIOD_CYCLES-1.
- Channel pointer: starts at 0 and advances by one after every completed measurement, wrapping from N_CH-1 to 0.
- FSM states and transitions:
  - IDLE → TRIG on a slot tick when `enable_i` is 1. If `enable_i` is 0 at the tick, the slot is skipped.
  - TRIG → WAIT_RISE after TRIG_CYCLES. `trigger_o[ch]` is high only while in TRIG.
  - WAIT_RISE → MEASURE on a synchronized rising edge of `echo_i[ch]`.
  - WAIT_RISE → DONE with a timeout result (count = 0) if ECHO_TIMEOUT cycles elapse without a rising edge. An echo line that is already high or stuck high produces no edge and therefore times out.
  - MEASURE → DONE on a synchronized falling edge. The count equals the number of cycles the synchronized echo was high.
  - MEASURE → DONE with a timeout result if the count reaches ECHO_TIMEOUT. The count saturates at ECHO_TIMEOUT.
  - DONE → IDLE after one cycle.
- Classification of each result:
  - near: not a timeout, count > 0, and count < NEAR_THRESHOLD.
  - far: a timeout, or count ≥ FAR_THRESHOLD.
  - anything between the thresholds: no class; streaks are unchanged.
- Per-channel debounce:
  - A near result increments the near streak and clears the far streak; a far result does the reverse.
  - Each streak saturates at DEBOUNCE.
  - The flag sets when the near streak reaches DEBOUNCE and clears when the far streak reaches DEBOUNCE.
- Dropping `enable_i` mid-measurement does not abort it; the measurement completes and reports normally.

## Timing
- All outputs reset to 0, and the internal state resets to IDLE with channel 0 and all streaks at 0.
- Reset asserted mid-operation drops `trigger_o` immediately (asynchronous) and discards any partial measurement.
- The first slot tick occurs PERIOD_CYCLES-1 cycles after reset release. The matching `trigger_o[0]` rises on the following edge.
- The `trigger_o` high time is exactly TRIG_CYCLES cycles.
- The rise of the `meas_valid_o` strobe depends on the result type:
  - Normal result: 3 edges after the raw `echo_i` fall (2 synchronizer edges plus the DONE register).
  - Timeout result: 1 edge after the timeout count is reached.
- `meas_ch_o`, `meas_count_o` and `meas_timeout_o` are valid only while `meas_valid_o` is high and hold their values until the next strobe.
- `object_detected_o[ch]` updates on the same edge as `meas_valid_o`.
- Echo activity on any non-selected channel is ignored.

## Structure
- Shared package `ultrasonic_pkg`:
  - the FSM state encoding (IDLE, TRIG, WAIT_RISE, MEASURE, DONE);
  - the class encoding (NONE, NEAR, FAR);
  - a channel-width helper function.
- Sub-module `ultrasonic_debounce`: streak counters and flag for one channel, instantiated N_CH times. Inputs are the result strobe and its class; the output is the flag.
- The top level contains the synchronizers, slot timer, FSM, counter and classifier.

## Test plan
All scenarios use N_CH=2, TRIG=10, TIMEOUT=800, PERIOD=2000, NEAR=100, FAR=150, DEBOUNCE=2.
1. Reset release with echo idle:
   - `trigger_o[0]` rises at edge 2000 and stays high 10 cycles.
   - A timeout is reported with count 0 on channel 0.
   - The next slot fires `trigger_o[1]`.
2. Echo on ch0 high for 60 cycles, two consecutive slots of ch0:
   - Each result is count=60 with `meas_timeout_o`=0.
   - `object_detected_o[0]` is 0 after the first result and 1 after the second.
3. ch0 flag set, then echoes of 120 cycles (between the thresholds):
   - The flag stays 1.
   - A subsequent run of two 200-cycle results clears it.
4. Echo held high for 1000 cycles:
   - Count saturates at 800 and `meas_timeout_o`=1.
   - The result classifies as far.
5. `enable_i` drops during MEASURE:
   - The current result is still reported.
   - No trigger fires on later ticks until `enable_i` returns.
6. `rst` asserted during TRIG:
   - `trigger_o` falls asynchronously and all outputs read 0.
   - After release, the sequence restarts at channel 0.
